calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
- Keypad sequencing controller for the calculator top.
- Converts a stream of decoded key events (digits, operators, equals, clear) into the operand-load strobes and operator select the datapath consumes: is_num, is_op1, is_op2, num_val, op_val, save.
- Tracks the entry phase (operand 1, operand 2, result) and the digit count per operand, and rejects illegal key sequences.
- Sits between the keypad decoder and top.

Parameters:
- MAX_DIGITS, 4, maximum BCD digits accepted per operand (one 16-bit BCD word).
- CNT_W, 3, width of the digit counter; must hold MAX_DIGITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle
- key_code  in  4  0-9 digit; 4'hB equals; 4'hC clear; 4'hD add; 4'hE subtract; 4'hA, 4'hF reserved
- is_num  out  1  one-cycle digit-load strobe to datapath
- is_op1  out  1  level: digits go to operand 1
- is_op2  out  1  level: digits go to operand 2
- num_val  out  4  digit value, valid while is_num=1
- op_val  out  4  selected operator code (4'hD add, 4'hE sub)
- save  out  1  one-cycle strobe: latch ALU result
- clr  out  1  one-cycle strobe: clear datapath operands
- result_valid  out  1  level: result on display is current
- key_rej  out  1  one-cycle strobe: last key ignored
- dig_cnt  out  CNT_W  digits entered in current operand

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n. While rst_n=0 at a rising edge, all outputs take their reset values: state=S_OP1, is_op1=1, is_op2=0, is_num=0, num_val=0, op_val=4'hD, save=0, clr=0, result_valid=0, key_rej=0, dig_cnt=0.
- Timing: all outputs are registered; response appears on the edge after the key_valid cycle (latency 1). Back-to-back keys on consecutive cycles are legal and each is processed.
- Strobes: is_num, save, clr and key_rej are high for exactly one cycle per accepted or rejected key, else 0. is_op1/is_op2 are one-hot and update on the same edge as any is_num they qualify.
- Key priority: clear (4'hC) beats everything in any state. It pulses clr, goes to S_OP1, sets is_op1=1, is_op2=0, dig_cnt=0, result_valid=0, op_val=4'hD.
- Reserved codes: always pulse key_rej; no other effect.
- S_OP1, digit:
  - dig_cnt<MAX_DIGITS: is_num=1, num_val=digit, dig_cnt+1.
  - dig_cnt=MAX_DIGITS: key_rej, no load.
- S_OP1, operator: op_val<=code, go to S_OP2, is_op1=0, is_op2=1, dig_cnt=0. Legal even with dig_cnt=0 (operand 1 = 0).
- S_OP1, equals: key_rej.
- S_OP2, digit: same as S_OP1, loading operand 2.
- S_OP2, operator:
  - dig_cnt=0: replaces op_val.
  - otherwise: key_rej.
- S_OP2, equals:
  - dig_cnt>0: save=1, go to S_RES, result_valid=1, is_op2 stays 1 (op2 display frozen).
  - dig_cnt=0: key_rej.
- S_RES, digit: starts a new calculation. Go to S_OP1, is_op1=1, is_op2=0, result_valid=0, is_num=1 with num_val=digit, dig_cnt=1. No clr; the datapath shifts the new digit into op1.
- S_RES, operator or equals: key_rej, state unchanged.
- op_val holds between operator keys. It survives S_RES and the next S_OP1 until a new operator is accepted or clear.
- dig_cnt saturates at MAX_DIGITS and never wraps.
- rst_n low in the middle of a sequence: the state is lost and the block resumes from reset values. A key_valid in the same cycle as rst_n=0 is discarded.

Decomposition:
- calc_pkg holds:
  - key code constants: KEY_EQ=4'hB, KEY_CLR=4'hC, OP_ADD=4'hD, OP_SUB=4'hE;
  - the state encoding S_OP1/S_OP2/S_RES;
  - a function is_digit(code) (code<=9).
- calc_pkg is shared with top and the keypad decoder.
- Single module, no sub-module: one next-state block plus a registered output block.

Test Plan:
- Reset, then keys 1,2,3,4 -> four is_num pulses with num_val 1,2,3,4, is_op1=1, dig_cnt=4. Fifth digit 5 -> key_rej=1, no is_num, dig_cnt stays 4.
- 1,2,3,4,D,5,6,7,8,B -> is_op2 rises on the edge after D; op_val=4'hD; is_num x4 on op2; save pulse 1 cycle after B; result_valid=1.
- After the previous scenario, keys E then 9 -> E rejected (key_rej) in S_RES, op_val stays 4'hD. Digit 9 -> is_op1=1, is_num with num_val=9, dig_cnt=1, result_valid=0.
- S_OP2 with dig_cnt=0: press E then D -> op_val ends 4'hD, no key_rej. Then B -> key_rej, no save.
- 1,2,C on back-to-back cycles -> clr pulse, dig_cnt=0, is_op1=1. C during S_OP2 with a simultaneous rst_n=0 -> reset values, no clr pulse.
- Reserved 4'hA in each state -> key_rej only; all other outputs unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, entry-phase encoding and key classification shared by the calculator blocks
package calc_pkg;

    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] OP_ADD  = 4'hD;
    localparam logic [3:0] OP_SUB  = 4'hE;

    typedef enum logic [1:0] {S_OP1, S_OP2, S_RES} state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if: key event input and datapath control outputs of the entry controller
interface calc_entry_ctrl_if #(parameter int CNT_W = 3);

    logic             key_valid;
    logic [3:0]       key_code;
    logic             is_num;
    logic             is_op1;
    logic             is_op2;
    logic [3:0]       num_val;
    logic [3:0]       op_val;
    logic             save;
    logic             clr;
    logic             result_valid;
    logic             key_rej;
    logic [CNT_W-1:0] dig_cnt;

    modport master (
        output key_valid, key_code,
        input  is_num, is_op1, is_op2, num_val, op_val, save, clr, result_valid, key_rej, dig_cnt
    );

    modport slave (
        input  key_valid, key_code,
        output is_num, is_op1, is_op2, num_val, op_val, save, clr, result_valid, key_rej, dig_cnt
    );

endinterface

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: turns keypad events into operand-load strobes, operator select and result save
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    calc_entry_ctrl_if.slave   bus
);

    state_t           state, state_nx;
    logic             num_q, num_nx;
    logic             op1_q, op1_nx;
    logic             op2_q, op2_nx;
    logic [3:0]       nv_q, nv_nx;
    logic [3:0]       op_q, op_nx;
    logic             save_q, save_nx;
    logic             clr_q, clr_nx;
    logic             rv_q, rv_nx;
    logic             rej_q, rej_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [3:0]       code;
    logic             full;
    logic             is_op;

    assign code  = bus.key_code;
    assign full  = cnt_q == CNT_W'(MAX_DIGITS);
    assign is_op = code == OP_ADD || code == OP_SUB;

    // Decode the current key against the entry phase; strobes default low, levels hold
    always_comb begin
        state_nx = state;
        num_nx   = 1'b0;
        save_nx  = 1'b0;
        clr_nx   = 1'b0;
        rej_nx   = 1'b0;
        op1_nx   = op1_q;
        op2_nx   = op2_q;
        nv_nx    = nv_q;
        op_nx    = op_q;
        rv_nx    = rv_q;
        cnt_nx   = cnt_q;
        if (bus.key_valid) begin
            if (code == KEY_CLR) begin
                clr_nx   = 1'b1;
                state_nx = S_OP1;
                op1_nx   = 1'b1;
                op2_nx   = 1'b0;
                cnt_nx   = '0;
                rv_nx    = 1'b0;
                op_nx    = OP_ADD;
            end else if (is_digit(code)) begin
                if (state == S_RES) begin
                    state_nx = S_OP1;
                    op1_nx   = 1'b1;
                    op2_nx   = 1'b0;
                    rv_nx    = 1'b0;
                    num_nx   = 1'b1;
                    nv_nx    = code;
                    cnt_nx   = CNT_W'(1);
                end else if (full) begin
                    rej_nx = 1'b1;
                end else begin
                    num_nx = 1'b1;
                    nv_nx  = code;
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end else if (is_op) begin
                if (state == S_OP1) begin
                    op_nx    = code;
                    state_nx = S_OP2;
                    op1_nx   = 1'b0;
                    op2_nx   = 1'b1;
                    cnt_nx   = '0;
                end else if (state == S_OP2 && cnt_q == '0) begin
                    op_nx = code;
                end else begin
                    rej_nx = 1'b1;
                end
            end else if (code == KEY_EQ && state == S_OP2 && cnt_q != '0) begin
                save_nx  = 1'b1;
                state_nx = S_RES;
                rv_nx    = 1'b1;
            end else begin
                rej_nx = 1'b1;
            end
        end
    end

    // Register phase and every output so the response lands one edge after the key
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_OP1;
            num_q  <= 1'b0;
            op1_q  <= 1'b1;
            op2_q  <= 1'b0;
            nv_q   <= '0;
            op_q   <= OP_ADD;
            save_q <= 1'b0;
            clr_q  <= 1'b0;
            rv_q   <= 1'b0;
            rej_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nx;
            num_q  <= num_nx;
            op1_q  <= op1_nx;
            op2_q  <= op2_nx;
            nv_q   <= nv_nx;
            op_q   <= op_nx;
            save_q <= save_nx;
            clr_q  <= clr_nx;
            rv_q   <= rv_nx;
            rej_q  <= rej_nx;
            cnt_q  <= cnt_nx;
        end
    end

    assign bus.is_num       = num_q;
    assign bus.is_op1       = op1_q;
    assign bus.is_op2       = op2_q;
    assign bus.num_val      = nv_q;
    assign bus.op_val       = op_q;
    assign bus.save         = save_q;
    assign bus.clr          = clr_q;
    assign bus.result_valid = rv_q;
    assign bus.key_rej      = rej_q;
    assign bus.dig_cnt      = cnt_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed and random key streams checked against a digit-list reference model
module tb_calc_entry_ctrl;

    localparam int MAXD  = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic             num;
        logic             op1;
        logic             op2;
        logic [3:0]       nv;
        logic [3:0]       op;
        logic             save;
        logic             clr;
        logic             rv;
        logic             rej;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    calc_entry_ctrl_if #(.CNT_W(CNT_W)) bus ();

    calc_entry_ctrl #(.MAX_DIGITS(MAXD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         phase = 0;
    logic [3:0] digs[$];
    logic [3:0] m_op = 4'hD;
    logic [3:0] m_nv = 4'h0;
    logic       m_rv = 1'b0;

    task automatic step(input logic v, input logic [3:0] c, input logic r);
        obs_t e;
        @(negedge clk);
        bus.key_valid = v;
        bus.key_code  = c;
        rst_n         = r;
        e = '0;
        if (!r) begin
            phase = 0;
            digs.delete();
            m_op = 4'hD;
            m_rv = 1'b0;
            m_nv = 4'h0;
        end else if (v) begin
            if (c == 4'hC) begin
                e.clr = 1'b1;
                phase = 0;
                digs.delete();
                m_op = 4'hD;
                m_rv = 1'b0;
            end else if (c == 4'hA || c == 4'hF) begin
                e.rej = 1'b1;
            end else if (c <= 4'd9) begin
                if (phase == 2) begin
                    phase = 0;
                    m_rv = 1'b0;
                    digs.delete();
                end
                if (digs.size() >= MAXD) e.rej = 1'b1;
                else begin
                    digs.push_back(c);
                    e.num = 1'b1;
                    m_nv = c;
                end
            end else if (c == 4'hB) begin
                if (phase == 1 && digs.size() > 0) begin
                    phase = 2;
                    e.save = 1'b1;
                    m_rv = 1'b1;
                end else e.rej = 1'b1;
            end else begin
                if (phase == 0) begin
                    phase = 1;
                    m_op = c;
                    digs.delete();
                end else if (phase == 1 && digs.size() == 0) m_op = c;
                else e.rej = 1'b1;
            end
        end
        e.op1 = phase == 0;
        e.op2 = phase != 0;
        e.nv  = m_nv;
        e.op  = m_op;
        e.rv  = m_rv;
        e.cnt = CNT_W'(digs.size());
        exp_q.push_back(e);
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) step(1'b1, seq[i], 1'b1);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.is_num, bus.is_op1, bus.is_op2, bus.num_val, bus.op_val, bus.save,
                     bus.clr, bus.result_valid, bus.key_rej, bus.dig_cnt};
                if (!e.num) a.nv = e.nv;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d: got num=%b op1=%b op2=%b nv=%h op=%h save=%b clr=%b rv=%b rej=%b cnt=%0d, want num=%b op1=%b op2=%b nv=%h op=%h save=%b clr=%b rv=%b rej=%b cnt=%0d",
                        vectors, a.num, a.op1, a.op2, a.nv, a.op, a.save, a.clr, a.rv, a.rej, a.cnt,
                        e.num, e.op1, e.op2, e.nv, e.op, e.save, e.clr, e.rv, e.rej, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
        step(1'b1, 4'hC, 1'b1);
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB});
        step(1'b0, 4'h0, 1'b1);
        keys('{4'hA, 4'hE, 4'hB, 4'h9, 4'hA, 4'hE, 4'hA, 4'hE, 4'hD, 4'hB, 4'h3, 4'hE, 4'hB});
        keys('{4'h1, 4'h2, 4'hC});
        keys('{4'h7, 4'hE, 4'h4});
        step(1'b1, 4'hC, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        keys('{4'hF, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hD});
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), $urandom_range(0, 199) != 0);
        step(1'b0, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
